load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
Memory-access stage that sits directly upstream of the byte-addressed data memory and drives its port 1. It accepts one load or store per handshake from the execute/MEM pipeline and sequences the accesses the memory needs, because the memory only moves 4 bytes per access:
- 64-bit accesses are split into two 32-bit accesses.
- Byte and halfword stores are done as read-modify-write.
- Load results are sign- or zero-extended.

The result is returned on a single-cycle response pulse.

Parameters:
ADDR_WIDTH, 64, width of the request address and of mem_addr
DATA_WIDTH, 64, width of wdata/rdata; only 64 is supported

Ports:
clk  in  1  single clock; all state updates on the rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  high only in IDLE
req_store  in  1  1 = store, 0 = load
req_funct3  in  3  RISC-V funct3: LB/LH/LW/LD/LBU/LHU/LWU, SB/SH/SW/SD
req_addr  in  ADDR_WIDTH  byte address
req_wdata  in  DATA_WIDTH  store data
resp_valid  out  1  one-cycle completion pulse (registered)
resp_rdata  out  DATA_WIDTH  extended load data; 0 for stores (registered)
resp_fault  out  1  access rejected (see Optional Feature); valid with resp_valid
mem_read_en  out  1  to memory MemReadEn1
mem_write_en  out  1  to memory MemWriteEn1
mem_addr  out  ADDR_WIDTH  to memory AddressBus1
mem_wdata  out  DATA_WIDTH  to memory DataMemoryInput1; bits [63:32] always 0
mem_rdata  in  DATA_WIDTH  from memory DataMemoryOutput1; valid the cycle after mem_read_en

Behaviour:
- Reset (asynchronous):
  - state = IDLE; resp_valid, resp_rdata, resp_fault = 0; captured request registers = 0.
  - mem_* enables are decoded from state, so they drop immediately when rst asserts.
  - A request interrupted by reset is abandoned and produces no response.
- Acceptance:
  - A request is accepted at the edge ending cycle T when req_valid && req_ready.
  - addr A, wdata, funct3 and store are captured; inputs are ignored outside IDLE.
  - A new request may be accepted in the same cycle resp_valid is high.
- States: IDLE, RD_LO, RD_HI, CAPTURE, WR_LO, WR_HI, RMW_RD, RMW_WR.
- RD_LO: read_en=1, addr=A.
  - Next state is RD_HI for LD, otherwise CAPTURE.
- RD_HI: read_en=1, addr=A+4.
  - Latch lo32 = mem_rdata[31:0]. Next state CAPTURE.
- CAPTURE: load resp_rdata from mem_rdata, then pulse resp_valid and go to IDLE.
  - LB / LBU: sign- / zero-extend [7:0].
  - LH / LHU: sign- / zero-extend [15:0].
  - LW / LWU: sign- / zero-extend [31:0].
  - LD: {mem_rdata[31:0], lo32}.
- WR_LO: write_en=1, addr=A, wdata={32'b0, wdata[31:0]}.
  - Next state WR_HI for SD; otherwise respond and go to IDLE.
- WR_HI: write_en=1, addr=A+4, wdata={32'b0, wdata[63:32]}.
  - Respond and go to IDLE.
- RMW_RD: read_en=1, addr=A. Next state RMW_WR.
- RMW_WR: write_en=1, addr=A; merge into the word just read, then respond and go to IDLE.
  - SB: wdata={32'b0, mem_rdata[31:8], req_wdata[7:0]}.
  - SH: wdata={32'b0, mem_rdata[31:16], req_wdata[15:0]}.
- Routing out of IDLE:
  - loads → RD_LO
  - SW / SD → WR_LO
  - SB / SH → RMW_RD
- Latency, counted from acceptance cycle T to the resp_valid cycle:
  - LB/LH/LW and unsigned variants: T+3
  - LD: T+4
  - SW: T+2
  - SD: T+3
  - SB/SH: T+3
- read_en and write_en are never both high in the same cycle.
- A+4 wraps modulo 2^ADDR_WIDTH.
- Unaligned addresses are passed through as-is; the memory is byte-addressed.
- Illegal funct3 (load 3'b111, store 3'b1xx):
  - No memory access.
  - resp_valid at T+1 with rdata=0, resp_fault=1.
- resp_fault=0 for all legal accesses unless the Optional Feature is enabled.

Optional Feature:
LSU_MISALIGN_TRAP_EN
- Defined: H/W/D accesses with A not naturally aligned (A[0] for H, A[1:0] for W, A[2:0] for D) are rejected. No memory access; resp_valid at T+1 with resp_fault=1, resp_rdata=0.
- Undefined: no alignment check; all legal funct3 accesses are performed; resp_fault is set only for illegal funct3.

Test Plan:
1. SD A=0x10, wdata=0x8877665544332211 → WR_LO writes 0x44332211 @0x10, WR_HI writes 0x88776655 @0x14, resp at T+3. Then LD 0x10 → resp_rdata=0x8877665544332211 at T+4.
2. After (1), SB A=0x11, wdata=0xAA → RMW_RD reads 0x55443322, RMW_WR writes 0x554433AA @0x11. Then LW 0x10 → 0x000000004433AA11.
3. After (1):
   - LB 0x17 → 0xFFFFFFFFFFFFFF88
   - LBU 0x17 → 0x0000000000000088
   - LH 0x16 → 0xFFFFFFFFFFFF8877
   - LWU 0x14 → 0x0000000088776655
4. rst asserted during the RD_HI cycle of an LD → mem_read_en=0 in the same cycle, no resp_valid. After release, req_ready=1 and state=IDLE.
5. req_valid held high with SW 0x20 then LW 0x20 (wdata=0xDEADBEEF) → LW accepted in the cycle resp_valid is high for the SW. LW returns 0xFFFFFFFFDEADBEEF.
6. LW A=0x12:
   - With LSU_MISALIGN_TRAP_EN: resp_fault=1, rdata=0 at T+1, no mem enables.
   - Without: normal read at T+3, resp_fault=0.
   - Either build: load funct3=3'b111 gives resp_fault=1 at T+1.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store sequencer for a byte-addressed memory that moves 4 bytes per access.
// Optional build macro LSU_MISALIGN_TRAP_EN rejects misaligned H/W/D accesses with resp_fault.
module load_store_unit #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_store,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_fault,
    output logic                  mem_read_en,
    output logic                  mem_write_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);
    typedef enum logic [2:0] {
        S_IDLE, S_RD_LO, S_RD_HI, S_CAPTURE, S_WR_LO, S_WR_HI, S_RMW_RD, S_RMW_WR
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [2:0]            r_funct3;
    logic                  r_store;
    logic [31:0]           r_lo32;
    logic                  r_resp_valid;
    logic                  r_resp_fault;
    logic [DATA_WIDTH-1:0] r_resp_rdata;

    logic                  w_accept;
    logic                  w_illegal;
    logic                  w_misalign;
    logic                  w_resp_set;
    logic                  w_resp_fault;
    logic                  w_lo32_en;
    logic [DATA_WIDTH-1:0] w_resp_rdata;
    logic                  w_mem_read_en;
    logic                  w_mem_write_en;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic [DATA_WIDTH-1:0] w_mem_wdata;
    logic [ADDR_WIDTH-1:0] w_addr_hi;
    logic                  w_unused_rdata_hi;

    function automatic logic [63:0] extend_load(input logic [2:0] f3, input logic [31:0] d,
                                                input logic [31:0] lo);
        logic [63:0] r;
        case (f3)
            3'b000:  r = {{56{d[7]}}, d[7:0]};
            3'b001:  r = {{48{d[15]}}, d[15:0]};
            3'b010:  r = {{32{d[31]}}, d[31:0]};
            3'b011:  r = {d[31:0], lo};
            3'b100:  r = {56'b0, d[7:0]};
            3'b101:  r = {48'b0, d[15:0]};
            3'b110:  r = {32'b0, d[31:0]};
            default: r = 64'b0;
        endcase
        return r;
    endfunction

    function automatic logic [63:0] merge_store(input logic half, input logic [31:0] word,
                                                input logic [15:0] wd);
        logic [63:0] r;
        if (half) begin
            r = {32'b0, word[31:16], wd[15:0]};
        end else begin
            r = {32'b0, word[31:8], wd[7:0]};
        end
        return r;
    endfunction

    // Only the low word of a memory read carries data.
    assign w_unused_rdata_hi = ^mem_rdata[DATA_WIDTH-1:32];
    assign w_addr_hi         = r_addr + ADDR_WIDTH'(3'd4);
    assign w_illegal         = req_store ? req_funct3[2] : (req_funct3 == 3'b111);

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                        ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00)) ||
                        ((req_funct3[1:0] == 2'b11) && (req_addr[2:0] != 3'b000));
`else
    assign w_misalign = 1'b0;
`endif

    // Next-state, memory-port decode and response generation
    always_comb begin
        w_next_state   = r_state;
        w_accept       = 1'b0;
        w_mem_read_en  = 1'b0;
        w_mem_write_en = 1'b0;
        w_mem_addr     = r_addr;
        w_mem_wdata    = '0;
        w_resp_set     = 1'b0;
        w_resp_rdata   = '0;
        w_resp_fault   = 1'b0;
        w_lo32_en      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_accept = 1'b1;
                    if (w_illegal || w_misalign) begin
                        w_resp_set   = 1'b1;
                        w_resp_fault = 1'b1;
                    end else if (!req_store) begin
                        w_next_state = S_RD_LO;
                    end else if (req_funct3[1]) begin
                        w_next_state = S_WR_LO;
                    end else begin
                        w_next_state = S_RMW_RD;
                    end
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_RD_LO: begin
                w_mem_read_en = 1'b1;
                w_next_state  = (r_funct3 == 3'b011) ? S_RD_HI : S_CAPTURE;
            end
            S_RD_HI: begin
                w_mem_read_en = 1'b1;
                w_mem_addr    = w_addr_hi;
                w_lo32_en     = 1'b1;
                w_next_state  = S_CAPTURE;
            end
            S_CAPTURE: begin
                w_resp_set   = 1'b1;
                w_resp_rdata = extend_load(r_funct3, mem_rdata[31:0], r_lo32);
                w_next_state = S_IDLE;
            end
            S_WR_LO: begin
                w_mem_write_en = 1'b1;
                w_mem_wdata    = {32'b0, r_wdata[31:0]};
                if (r_funct3[0]) begin
                    w_next_state = S_WR_HI;
                end else begin
                    w_resp_set   = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            S_WR_HI: begin
                w_mem_write_en = 1'b1;
                w_mem_addr     = w_addr_hi;
                w_mem_wdata    = {32'b0, r_wdata[63:32]};
                w_resp_set     = 1'b1;
                w_next_state   = S_IDLE;
            end
            S_RMW_RD: begin
                w_mem_read_en = 1'b1;
                w_next_state  = S_RMW_WR;
            end
            S_RMW_WR: begin
                w_mem_write_en = 1'b1;
                w_mem_wdata    = merge_store(r_funct3[0], mem_rdata[31:0], r_wdata[15:0]);
                w_resp_set     = 1'b1;
                w_next_state   = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // State register, captured request and registered response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_funct3     <= 3'b000;
            r_store      <= 1'b0;
            r_lo32       <= 32'b0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_fault <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_resp_valid <= w_resp_set;
            if (w_accept) begin
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
                r_funct3 <= req_funct3;
                r_store  <= req_store;
            end
            if (w_lo32_en) begin
                r_lo32 <= mem_rdata[31:0];
            end
            if (w_resp_set) begin
                r_resp_rdata <= w_resp_rdata;
                r_resp_fault <= w_resp_fault;
            end
        end
    end

    assign req_ready    = (r_state == S_IDLE);
    assign resp_valid   = r_resp_valid;
    assign resp_rdata   = r_resp_rdata;
    assign resp_fault   = r_resp_fault;
    assign mem_read_en  = w_mem_read_en;
    assign mem_write_en = w_mem_write_en;
    assign mem_addr     = w_mem_addr;
    assign mem_wdata    = w_mem_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: byte-array memory model, expected responses and writes queued at issue.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [63:0] req_addr = 64'h0;
    logic [63:0] req_wdata = 64'h0;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_fault;
    logic        mem_read_en;
    logic        mem_write_en;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata = 64'h0;

    typedef struct { int cyc; logic [63:0] rdata; logic fault; } resp_t;
    typedef struct { logic [63:0] addr; logic [31:0] data; } wr_t;
    resp_t exp_q[$];
    wr_t   wr_q[$];
    logic [7:0] mem [0:255];
    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    int t0, t1;

    load_store_unit #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_fault(resp_fault), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory model: registered read of 4 bytes; upper half and idle cycles carry junk.
    always @(posedge clk) begin
        if (mem_read_en) begin
            mem_rdata <= {32'hCAFEF00D, mem[8'(mem_addr[7:0] + 8'd3)], mem[8'(mem_addr[7:0] + 8'd2)],
                          mem[8'(mem_addr[7:0] + 8'd1)], mem[mem_addr[7:0]]};
        end else begin
            mem_rdata <= 64'hA5A5_A5A5_A5A5_A5A5;
        end
        if (mem_write_en) begin
            for (int i = 0; i < 4; i++) mem[8'(mem_addr[7:0] + 8'(i))] <= mem_wdata[8*i +: 8];
        end
    end

    // Monitor: pops expected writes and responses as the DUT presents them
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_read_en && mem_write_en) check("rd_wr_both_high", 64'd1, 64'd0);
            if (mem_write_en) begin
                if (wr_q.size() == 0) begin
                    check("unexpected_write", mem_addr, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    wr_t w;
                    w = wr_q.pop_front();
                    check("write_addr", mem_addr, w.addr);
                    check("write_data", mem_wdata, {32'h0, w.data});
                end
            end
            if (resp_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_resp", resp_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    resp_t e;
                    e = exp_q.pop_front();
                    check("resp_rdata", resp_rdata, e.rdata);
                    check("resp_fault", 64'(resp_fault), 64'(e.fault));
                    check("resp_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
        end
    end

    task automatic issue(input logic st, input logic [2:0] f3, input logic [63:0] a,
                         input logic [63:0] wd, input logic [63:0] er, input logic ef,
                         input int lat, input bit push, input bit hold, output int t);
        int n = 0;
        @(negedge clk);
        req_store  = st;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        req_valid  = 1'b1;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check("ready_timeout", 64'(req_ready), 64'd1);
        t = cyc;
        if (push) exp_q.push_back('{t + lat, er, ef});
        @(posedge clk);
        #1;
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || wr_q.size() != 0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            check("drain_timeout", 64'(exp_q.size() + wr_q.size()), 64'd0);
            exp_q.delete();
            wr_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        @(negedge clk);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_rdata", resp_rdata, 64'd0);
        check("rst_resp_fault", 64'(resp_fault), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_mem_en", 64'({mem_read_en, mem_write_en}), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // SD then LD
        wr_q.push_back('{64'h10, 32'h44332211});
        wr_q.push_back('{64'h14, 32'h88776655});
        issue(1'b1, 3'b011, 64'h10, 64'h8877665544332211, 64'h0, 1'b0, 3, 1'b1, 1'b0, t0);
        drain();
        issue(1'b0, 3'b011, 64'h10, 64'h0, 64'h8877665544332211, 1'b0, 4, 1'b1, 1'b0, t0);
        drain();

        // SB read-modify-write, then LW
        wr_q.push_back('{64'h11, 32'h554433AA});
        issue(1'b1, 3'b000, 64'h11, 64'hAA, 64'h0, 1'b0, 3, 1'b1, 1'b0, t0);
        drain();
        issue(1'b0, 3'b010, 64'h10, 64'h0, 64'h000000004433AA11, 1'b0, 3, 1'b1, 1'b0, t0);
        drain();

        // sign / zero extension
        issue(1'b0, 3'b000, 64'h17, 64'h0, 64'hFFFFFFFFFFFFFF88, 1'b0, 3, 1'b1, 1'b0, t0);
        drain();
        issue(1'b0, 3'b100, 64'h17, 64'h0, 64'h0000000000000088, 1'b0, 3, 1'b1, 1'b0, t0);
        drain();
        issue(1'b0, 3'b001, 64'h16, 64'h0, 64'hFFFFFFFFFFFF8877, 1'b0, 3, 1'b1, 1'b0, t0);
        drain();
        issue(1'b0, 3'b101, 64'h16, 64'h0, 64'h0000000000008877, 1'b0, 3, 1'b1, 1'b0, t0);
        drain();
        issue(1'b0, 3'b110, 64'h14, 64'h0, 64'h0000000088776655, 1'b0, 3, 1'b1, 1'b0, t0);
        drain();

        // SD/LD whose high half wraps the address space
        wr_q.push_back('{64'hFFFF_FFFF_FFFF_FFFC, 32'h01020304});
        wr_q.push_back('{64'h0, 32'h05060708});
        issue(1'b1, 3'b011, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0506070801020304, 64'h0, 1'b0, 3, 1'b1, 1'b0, t0);
        drain();
        issue(1'b0, 3'b011, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 64'h0506070801020304, 1'b0, 4, 1'b1, 1'b0, t0);
        drain();

        // reset during RD_HI of an LD abandons it
        issue(1'b0, 3'b011, 64'h10, 64'h0, 64'h0, 1'b0, 4, 1'b0, 1'b0, t0);
        @(posedge clk);
        #1;
        check("rdhi_read_en", 64'(mem_read_en), 64'd1);
        check("rdhi_addr", mem_addr, 64'h14);
        rst = 1'b1;
        #1;
        check("rst_drops_read_en", 64'(mem_read_en), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 64'(req_ready), 64'd1);
        repeat (5) @(negedge clk);

        // SW then LW back-to-back with req_valid held
        wr_q.push_back('{64'h20, 32'hDEADBEEF});
        issue(1'b1, 3'b010, 64'h20, 64'hDEADBEEF, 64'h0, 1'b0, 2, 1'b1, 1'b1, t0);
        issue(1'b0, 3'b010, 64'h20, 64'h0, 64'hFFFFFFFFDEADBEEF, 1'b0, 3, 1'b1, 1'b0, t1);
        check("b2b_accept_cycle", 64'(t1), 64'(t0 + 2));
        drain();

        // SH read-modify-write, then LW
        wr_q.push_back('{64'h22, 32'h00001234});
        issue(1'b1, 3'b001, 64'h22, 64'h1234, 64'h0, 1'b0, 3, 1'b1, 1'b0, t0);
        drain();
        issue(1'b0, 3'b010, 64'h20, 64'h0, 64'h000000001234BEEF, 1'b0, 3, 1'b1, 1'b0, t0);
        drain();

        // misaligned LW
`ifdef LSU_MISALIGN_TRAP_EN
        issue(1'b0, 3'b010, 64'h12, 64'h0, 64'h0, 1'b1, 1, 1'b1, 1'b0, t0);
        @(negedge clk);
        check("misalign_no_mem", 64'({mem_read_en, mem_write_en}), 64'd0);
        drain();
`else
        issue(1'b0, 3'b010, 64'h12, 64'h0, 64'h0000000066554433, 1'b0, 3, 1'b1, 1'b0, t0);
        drain();
`endif

        // illegal funct3 for load and store
        issue(1'b0, 3'b111, 64'h10, 64'h0, 64'h0, 1'b1, 1, 1'b1, 1'b0, t0);
        @(negedge clk);
        check("illegal_ld_no_mem", 64'({mem_read_en, mem_write_en}), 64'd0);
        drain();
        issue(1'b1, 3'b100, 64'h10, 64'h1234, 64'h0, 1'b1, 1, 1'b1, 1'b0, t0);
        @(negedge clk);
        check("illegal_st_no_mem", 64'({mem_read_en, mem_write_en}), 64'd0);
        drain();

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
